// File: rtl/gray_monitor_if.sv
// Signal bundle between the Gray-code counter stage and its sequence monitor.
// Directions are named from the monitor's side: i_* feed it, o_* are its results.
interface gray_monitor_if #(
  parameter int WRAP_W = 8
);
  logic [2:0]        i_gray;
  logic              i_ovf_in;
  logic              i_clr_err;
  logic [2:0]        o_bin;
  logic              o_step_pulse;
  logic [WRAP_W-1:0] o_wrap_count;
  logic              o_locked;
  logic              o_error;
  logic [1:0]        o_err_code;

  modport master (
    output i_gray, i_ovf_in, i_clr_err,
    input  o_bin, o_step_pulse, o_wrap_count, o_locked, o_error, o_err_code
  );

  modport slave (
    input  i_gray, i_ovf_in, i_clr_err,
    output o_bin, o_step_pulse, o_wrap_count, o_locked, o_error, o_err_code
  );
endinterface

// File: rtl/gray_monitor.sv
// Checks a 3-bit Gray counter stream: hold or +1 per cycle, first wrap aligned with overflow.
// One-cycle latency from sample to Bin/flags; first violation is latched until ClrErr.
module gray_monitor #(
  parameter int WRAP_W = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  gray_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_RESYNC = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_JUMP = 2'b01;
  localparam logic [1:0] CODE_OVF  = 2'b10;
  localparam logic [1:0] CODE_BAD  = 2'b11;

  state_t            r_state;
  logic [2:0]        r_bin;       // doubles as the previous-sample reference
  logic              r_prev_ovf;
  logic              r_step;
  logic [WRAP_W-1:0] r_wrap_cnt;
  logic              r_locked;
  logic              r_error;
  logic [1:0]        r_err_code;

  state_t            w_next_state;
  logic [2:0]        w_n;
  logic [2:0]        w_inc;
  logic              w_wrap;
  logic              w_ovf_bad;
  logic              w_step;
  logic [WRAP_W-1:0] w_wrap_cnt;
  logic              w_error;
  logic [1:0]        w_err_code;

  assign w_n    = {mon.i_gray[2],
                   mon.i_gray[2] ^ mon.i_gray[1],
                   mon.i_gray[2] ^ mon.i_gray[1] ^ mon.i_gray[0]};
  assign w_inc  = r_bin + 3'd1;
  assign w_wrap = (r_bin == 3'd7) && (w_n == 3'd0);

  // Overflow must rise exactly on the first wrap and never fall afterwards.
  assign w_ovf_bad = (!r_prev_ovf &&  mon.i_ovf_in && !w_wrap) ||
                     ( w_wrap && !r_prev_ovf && !mon.i_ovf_in) ||
                     ( r_prev_ovf && !mon.i_ovf_in);

  always_comb begin
    w_next_state = r_state;
    w_step       = 1'b0;
    w_wrap_cnt   = r_wrap_cnt;
    w_error      = r_error;
    w_err_code   = r_err_code;
    case (r_state)
      ST_INIT: begin
        if ((w_n == 3'd0) && !mon.i_ovf_in) begin
          w_next_state = ST_TRACK;
        end else begin
          w_next_state = ST_ERROR;
          w_error      = 1'b1;
          w_err_code   = CODE_BAD;
        end
      end
      ST_RESYNC: begin
        w_next_state = ST_TRACK;
      end
      ST_TRACK: begin
        if ((w_n != r_bin) && (w_n != w_inc)) begin
          w_next_state = ST_ERROR;
          w_error      = 1'b1;
          w_err_code   = CODE_JUMP;
        end else if (w_ovf_bad) begin
          w_next_state = ST_ERROR;
          w_error      = 1'b1;
          w_err_code   = CODE_OVF;
        end else if (w_n == w_inc) begin
          w_step = 1'b1;
          if (w_wrap && (r_wrap_cnt != {WRAP_W{1'b1}})) begin
            w_wrap_cnt = r_wrap_cnt + 1'b1;
          end
        end
      end
      ST_ERROR: begin
        if (mon.i_clr_err) begin
          w_next_state = ST_RESYNC;
          w_error      = 1'b0;
          w_err_code   = CODE_NONE;
        end
      end
      default: begin
        w_next_state = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_INIT;
      r_bin      <= 3'd0;
      r_prev_ovf <= 1'b0;
      r_step     <= 1'b0;
      r_wrap_cnt <= '0;
      r_locked   <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= CODE_NONE;
    end else begin
      r_state    <= w_next_state;
      r_bin      <= w_n;
      r_prev_ovf <= mon.i_ovf_in;
      r_step     <= w_step;
      r_wrap_cnt <= w_wrap_cnt;
      r_locked   <= (w_next_state == ST_TRACK);
      r_error    <= w_error;
      r_err_code <= w_err_code;
    end
  end

  assign mon.o_bin        = r_bin;
  assign mon.o_step_pulse = r_step;
  assign mon.o_wrap_count = r_wrap_cnt;
  assign mon.o_locked     = r_locked;
  assign mon.o_error      = r_error;
  assign mon.o_err_code   = r_err_code;

endmodule

// File: tb/tb_gray_monitor.sv
// Directed bench for gray_monitor: two instances (8-bit and 2-bit wrap counters) share one stimulus.
module tb_gray_monitor;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  gray_monitor_if #(.WRAP_W(8)) if8 ();
  gray_monitor_if #(.WRAP_W(2)) if2 ();

  gray_monitor #(.WRAP_W(8)) u_dut8 (.i_clk(clk), .i_reset(rst), .mon(if8.slave));
  gray_monitor #(.WRAP_W(2)) u_dut2 (.i_clk(clk), .i_reset(rst), .mon(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] gray_of(input int b);
    logic [2:0] v;
    v = 3'(b);
    return v ^ (v >> 1);
  endfunction

  // Apply one sample to both instances, clock it in, then look #1 after the edge.
  task automatic cyc(input int b, input logic ovf, input logic clr, input logic r);
    rst           = r;
    if8.i_gray    = gray_of(b);
    if2.i_gray    = gray_of(b);
    if8.i_ovf_in  = ovf;
    if2.i_ovf_in  = ovf;
    if8.i_clr_err = clr;
    if2.i_clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input int bin, input int step, input int w8,
                            input int w2, input int lck, input int err, input int code);
    check({tag, ".bin"},   int'(if8.o_bin),        bin);
    check({tag, ".step"},  int'(if8.o_step_pulse), step);
    check({tag, ".wrap8"}, int'(if8.o_wrap_count), w8);
    check({tag, ".wrap2"}, int'(if2.o_wrap_count), w2);
    check({tag, ".lock"},  int'(if8.o_locked),     lck);
    check({tag, ".err"},   int'(if8.o_error),      err);
    check({tag, ".code"},  int'(if8.o_err_code),   code);
  endtask

  initial begin
    rst = 1'b1;
    if8.i_gray = 3'd0; if2.i_gray = 3'd0;
    if8.i_ovf_in = 1'b0; if2.i_ovf_in = 1'b0;
    if8.i_clr_err = 1'b0; if2.i_clr_err = 1'b0;
    @(negedge clk);

    // Reset state
    cyc(0, 1'b0, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b0, 1'b1);
    expect_all("reset", 0, 0, 0, 0, 0, 0, 0);

    // Count 0..7: lock on first sample, step pulse on each +1
    for (int b = 0; b < 8; b++) begin
      cyc(b, 1'b0, 1'b0, 1'b0);
      expect_all($sformatf("count%0d", b), b, (b != 0) ? 1 : 0, 0, 0, 1, 0, 0);
    end

    // First wrap with overflow rising, then four more wraps with overflow held high
    cyc(0, 1'b1, 1'b0, 1'b0);
    expect_all("wrap1", 0, 1, 1, 1, 1, 0, 0);
    for (int w = 2; w <= 5; w++) begin
      for (int b = 1; b < 8; b++) cyc(b, 1'b1, 1'b0, 1'b0);
      check("pre_wrap.step", int'(if8.o_step_pulse), 1);
      cyc(0, 1'b1, 1'b0, 1'b0);
      expect_all($sformatf("wrap%0d", w), 0, 1, w, (w < 3) ? w : 3, 1, 0, 0);
    end

    // Jump 1 -> 3, then the error state freezes code/count and suppresses steps
    cyc(1, 1'b1, 1'b0, 1'b0);
    check("at1.step", int'(if8.o_step_pulse), 1);
    cyc(3, 1'b1, 1'b0, 1'b0);
    expect_all("jump", 3, 0, 5, 3, 0, 1, 1);
    cyc(4, 1'b1, 1'b0, 1'b0);
    expect_all("err_hold1", 4, 0, 5, 3, 0, 1, 1);
    cyc(6, 1'b0, 1'b0, 1'b0);
    expect_all("err_hold2", 6, 0, 5, 3, 0, 1, 1);

    // Overflow rising without a wrap (hold at 2)
    cyc(0, 1'b0, 1'b0, 1'b1);
    expect_all("reset2", 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1'b0, 1'b0, 1'b0);
    cyc(1, 1'b0, 1'b0, 1'b0);
    cyc(2, 1'b0, 1'b0, 1'b0);
    cyc(2, 1'b1, 1'b0, 1'b0);
    expect_all("ovf_nowrap", 2, 0, 0, 0, 0, 1, 2);

    // Wrap with overflow still low
    cyc(0, 1'b0, 1'b0, 1'b1);
    for (int b = 0; b < 8; b++) cyc(b, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b0);
    expect_all("wrap_noovf", 0, 0, 0, 0, 0, 1, 2);

    // Overflow falling after a legal wrap
    cyc(0, 1'b0, 1'b0, 1'b1);
    for (int b = 0; b < 8; b++) cyc(b, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b0);
    check("legal_wrap.wrap8", int'(if8.o_wrap_count), 1);
    cyc(1, 1'b0, 1'b0, 1'b0);
    expect_all("ovf_fall", 1, 0, 1, 1, 0, 1, 2);

    // Bad start, clear, resync, track again
    cyc(0, 1'b0, 1'b0, 1'b1);
    cyc(2, 1'b0, 1'b0, 1'b0);
    expect_all("bad_start", 2, 0, 0, 0, 0, 1, 3);
    cyc(4, 1'b0, 1'b1, 1'b0);
    expect_all("clr", 4, 0, 0, 0, 0, 0, 0);
    cyc(4, 1'b0, 1'b0, 1'b0);
    expect_all("resync", 4, 0, 0, 0, 1, 0, 0);
    cyc(5, 1'b0, 1'b0, 1'b0);
    expect_all("post_resync", 5, 1, 0, 0, 1, 0, 0);
    cyc(6, 1'b0, 1'b1, 1'b0);
    expect_all("clr_ignored", 6, 1, 0, 0, 1, 0, 0);

    // Reset in the middle of a tracked sequence returns to INIT
    cyc(7, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b0);
    expect_all("pre_rst_wrap", 0, 1, 1, 1, 1, 0, 0);
    cyc(1, 1'b1, 1'b0, 1'b1);
    expect_all("mid_reset", 0, 0, 0, 0, 0, 0, 0);
    cyc(2, 1'b0, 1'b0, 1'b0);
    expect_all("init_after_rst", 2, 0, 0, 0, 0, 1, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
